// File: rtl/multicycle_maindec.sv
// Multicycle LEGv8 main control FSM: latches the opcode in FETCH and sequences
// DECODE/EXEC/MEM/WB, with illegal-opcode and data-memory-timeout traps.
module multicycle_maindec #(
  parameter bit EN_IMM      = 1'b1,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [10:0]      Op,
  input  logic             ir_valid,
  input  logic             dmem_ready,
  output logic             IRWrite,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic [1:0]       ALUOp,
  output logic             PCWrite,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_FAULT  = 3'd5;

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef struct packed {
    logic ldur;
    logic stur;
    logic cbz;
    logic rtype;
    logic imm;
  } dec_t;

  logic [2:0]       state_q, state_d;
  logic [10:0]      op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;
  dec_t             dec;

  always_comb begin
    dec = '0;
    casez (op_q)
      11'b11111000010: dec.ldur  = 1'b1;
      11'b11111000000: dec.stur  = 1'b1;
      11'b10110100???: dec.cbz   = 1'b1;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: dec.rtype = 1'b1;
      11'b1001000100?,
      11'b1101000100?: dec.imm   = EN_IMM;
      default:         dec       = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    IRWrite  = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
    PCWrite  = 1'b0;
    case (state_q)
      S_FETCH: begin
        // IRWrite is masked while reset is held so every control reads 0 in reset
        if (ir_valid) begin
          IRWrite = reset;
          op_d    = Op;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = (|dec) ? S_EXEC : S_FAULT;
      S_EXEC: begin
        cnt_d = '0;
        if (dec.rtype) begin
          ALUOp   = 2'b10;
          state_d = S_WB;
        end else if (dec.imm) begin
          ALUSrc  = 1'b1;
          state_d = S_WB;
        end else if (dec.ldur || dec.stur) begin
          ALUSrc  = 1'b1;
          Reg2Loc = dec.stur;
          state_d = S_MEM;
        end else begin
          Reg2Loc = 1'b1;
          ALUOp   = 2'b01;
          Branch  = 1'b1;
          PCWrite = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        MemRead  = dec.ldur;
        MemWrite = dec.stur;
        // a ready on the last allowed cycle beats the timeout
        if (dmem_ready) begin
          PCWrite = dec.stur;
          state_d = dec.stur ? S_FETCH : S_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = dec.ldur;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FAULT;
    endcase
    retired_d = retired_q + (PCWrite ? CNT_W'(1) : CNT_W'(0));
    illegal_d = illegal_q | (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      cnt_q     <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign state   = state_q;
  assign retired = retired_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_maindec.sv
// Directed bench for multicycle_maindec: two instances (immediates enabled and
// disabled) share stimulus; control vectors are checked against hand values.
module tb_multicycle_maindec;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  // control vector: IRWrite Reg2Loc ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0] PCWrite
  localparam logic [10:0] C_IRW  = 11'h400;
  localparam logic [10:0] C_R2L  = 11'h200;
  localparam logic [10:0] C_ALUS = 11'h100;
  localparam logic [10:0] C_M2R  = 11'h080;
  localparam logic [10:0] C_RW   = 11'h040;
  localparam logic [10:0] C_MR   = 11'h020;
  localparam logic [10:0] C_MW   = 11'h010;
  localparam logic [10:0] C_BR   = 11'h008;
  localparam logic [10:0] C_OP10 = 11'h004;
  localparam logic [10:0] C_OP01 = 11'h002;
  localparam logic [10:0] C_PCW  = 11'h001;
  localparam logic [10:0] C_NONE = 11'h000;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Op;
  logic        ir_valid, dmem_ready;

  logic        IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, PCWrite, illegal;
  logic [1:0]  ALUOp;
  logic [2:0]  state;
  logic [31:0] retired;
  logic        IRWrite0, Reg2Loc0, ALUSrc0, MemtoReg0, RegWrite0, MemRead0, MemWrite0, Branch0, PCWrite0, illegal0;
  logic [1:0]  ALUOp0;
  logic [2:0]  state0;
  logic [31:0] retired0;
  logic [10:0] ctl, ctl0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_maindec #(.EN_IMM(1'b1), .MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .Op(Op), .ir_valid(ir_valid), .dmem_ready(dmem_ready),
    .IRWrite(IRWrite), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
    .ALUOp(ALUOp), .PCWrite(PCWrite), .illegal(illegal), .state(state), .retired(retired)
  );

  multicycle_maindec #(.EN_IMM(1'b0), .MEM_TIMEOUT(16), .CNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .Op(Op), .ir_valid(ir_valid), .dmem_ready(dmem_ready),
    .IRWrite(IRWrite0), .Reg2Loc(Reg2Loc0), .ALUSrc(ALUSrc0), .MemtoReg(MemtoReg0),
    .RegWrite(RegWrite0), .MemRead(MemRead0), .MemWrite(MemWrite0), .Branch(Branch0),
    .ALUOp(ALUOp0), .PCWrite(PCWrite0), .illegal(illegal0), .state(state0), .retired(retired0)
  );

  assign ctl  = {IRWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, PCWrite};
  assign ctl0 = {IRWrite0, Reg2Loc0, ALUSrc0, MemtoReg0, RegWrite0, MemRead0, MemWrite0, Branch0, ALUOp0, PCWrite0};

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] st, input logic [10:0] c);
    chkv({tag, "_state"}, 32'(state), 32'(st));
    chkv({tag, "_ctl"}, 32'(ctl), 32'(c));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic iv, input logic [10:0] op, input logic rdy);
    ir_valid   = iv;
    Op         = op;
    dmem_ready = rdy;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drv(1'b1, OP_ADD, 1'b0);
    tick(); tick();
    chk("rst", 3'd0, C_NONE);
    chkv("rst_ret", retired, 0);
    chkv("rst_ill", 32'(illegal), 0);

    // ADD: 0,1,2,4,0 and Op changes after fetch must not matter
    reset = 1'b1; #1;
    chk("add_f", 3'd0, C_IRW);
    tick(); drv(1'b0, 11'h000, 1'b0);
    chk("add_d", 3'd1, C_NONE);
    tick(); chk("add_e", 3'd2, C_OP10);
    tick(); chk("add_wb", 3'd4, C_RW | C_PCW);
    tick(); chk("add_done", 3'd0, C_NONE);
    chkv("add_ret", retired, 1);

    // LDUR with three wait cycles
    drv(1'b1, OP_LDUR, 1'b0);
    chk("ld_f", 3'd0, C_IRW);
    tick(); drv(1'b0, OP_LDUR, 1'b0);
    chk("ld_d", 3'd1, C_NONE);
    tick(); chk("ld_e", 3'd2, C_ALUS);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_wait", 3'd3, C_MR);
      tick();
    end
    drv(1'b0, OP_LDUR, 1'b1);
    chk("ld_rdy", 3'd3, C_MR);
    tick(); drv(1'b0, OP_LDUR, 1'b0);
    chk("ld_wb", 3'd4, C_M2R | C_RW | C_PCW);
    tick(); chk("ld_done", 3'd0, C_NONE);
    chkv("ld_ret", retired, 2);

    // CBZ retires out of EXEC
    drv(1'b1, OP_CBZ, 1'b0);
    chk("cbz_f", 3'd0, C_IRW);
    tick(); drv(1'b0, OP_CBZ, 1'b0);
    chk("cbz_d", 3'd1, C_NONE);
    tick(); chk("cbz_e", 3'd2, C_R2L | C_OP01 | C_BR | C_PCW);
    tick(); chk("cbz_done", 3'd0, C_NONE);
    chkv("cbz_ret", retired, 3);

    // ADDI: legal on dut, illegal on dut0
    drv(1'b1, OP_ADDI, 1'b0);
    chk("addi_f", 3'd0, C_IRW);
    tick(); drv(1'b0, OP_ADDI, 1'b0);
    chkv("addi0_d", 32'(state0), 1);
    tick(); chk("addi_e", 3'd2, C_ALUS);
    chkv("addi0_fault", 32'(state0), 5);
    chkv("addi0_ill", 32'(illegal0), 1);
    chkv("addi0_ctl", 32'(ctl0), 0);
    tick(); chk("addi_wb", 3'd4, C_RW | C_PCW);
    tick(); chkv("addi_ret", retired, 4);
    for (int i = 0; i < 10; i++) begin
      drv(1'b0, (i % 2 == 0) ? OP_ADD : OP_CBZ, (i % 2 == 0) ? 1'b1 : 1'b0);
      chkv("fault0_state", 32'(state0), 5);
      chkv("fault0_ctl", 32'(ctl0), 0);
      tick();
    end
    chkv("fault0_ret", retired0, 3);
    chkv("fault0_ill", 32'(illegal0), 1);

    // STUR with no ready: 16 MEM cycles then FAULT
    drv(1'b1, OP_STUR, 1'b0);
    chk("stto_f", 3'd0, C_IRW);
    tick(); drv(1'b0, OP_STUR, 1'b0);
    chk("stto_d", 3'd1, C_NONE);
    tick(); chk("stto_e", 3'd2, C_R2L | C_ALUS);
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("stto_wait", 3'd3, C_MW);
      tick();
    end
    chk("stto_fault", 3'd5, C_NONE);
    chkv("stto_ill", 32'(illegal), 1);
    chkv("stto_ret", retired, 4);

    reset = 1'b0;
    tick(); reset = 1'b1; #1;
    chk("rst2", 3'd0, C_NONE);
    chkv("rst2_ret", retired, 0);
    chkv("rst2_ill", 32'(illegal), 0);
    chkv("rst2_ill0", 32'(illegal0), 0);

    // STUR with ready on the last allowed cycle
    drv(1'b1, OP_STUR, 1'b0);
    tick(); drv(1'b0, OP_STUR, 1'b0);
    tick(); tick();
    for (int i = 0; i < 15; i++) begin
      chk("stl_wait", 3'd3, C_MW);
      tick();
    end
    drv(1'b0, OP_STUR, 1'b1);
    chk("stl_last", 3'd3, C_MW | C_PCW);
    tick(); drv(1'b0, OP_STUR, 1'b0);
    chk("stl_done", 3'd0, C_NONE);
    chkv("stl_ret", retired, 1);

    // undefined opcode traps after DECODE
    drv(1'b1, OP_BAD, 1'b0);
    tick(); drv(1'b0, OP_BAD, 1'b0);
    chk("bad_d", 3'd1, C_NONE);
    tick(); chk("bad_fault", 3'd5, C_NONE);
    chkv("bad_ill", 32'(illegal), 1);
    chkv("bad_ret", retired, 1);

    // reset during LDUR MEM aborts without retiring
    reset = 1'b0;
    tick(); reset = 1'b1;
    drv(1'b1, OP_ADD, 1'b0);
    tick(); drv(1'b0, OP_ADD, 1'b0);
    tick(); tick(); tick();
    chkv("pre_ret", retired, 1);
    drv(1'b1, OP_LDUR, 1'b0);
    tick(); drv(1'b0, OP_LDUR, 1'b0);
    tick(); tick();
    chk("abort_mem", 3'd3, C_MR);
    reset = 1'b0;
    drv(1'b1, OP_LDUR, 1'b1);
    tick();
    chk("abort", 3'd0, C_NONE);
    chkv("abort_ret", retired, 0);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
